// File: rtl/cp0.sv
// cp0: coprocessor-0 register file (SR, Cause, EPC, PRId) and the
// exception/interrupt arbiter for the M stage of the pipelined MIPS core.
// Optional feature macro: CP0_COUNT_EN adds Count (9), Compare (11) and a
// sticky timer interrupt folded into HWInt[5].
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_1900
) (
  input  logic        CP0_i_Clk,
  input  logic        CP0_i_Reset_n,
  input  logic [4:0]  CP0_i_Addr,
  input  logic [31:0] CP0_i_WData,
  input  logic        CP0_i_WE,
  input  logic [31:0] CP0_i_PC,
  input  logic        CP0_i_BD,
  input  logic        CP0_i_ExcValid,
  input  logic [4:0]  CP0_i_ExcCode,
  input  logic [5:0]  CP0_i_HWInt,
  input  logic        CP0_i_EXLClr,
  output logic [31:0] CP0_o_RData,
  output logic [31:0] CP0_o_EPC,
  output logic        CP0_o_Req
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned IW   = 6;
  localparam int unsigned CW   = 5;

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  logic [IW-1:0]   sr_im;
  logic            sr_exl;
  logic            sr_ie;
  logic            cause_bd;
  logic [IW-1:0]   cause_ip;
  logic [CW-1:0]   cause_exc;
  logic [XLEN-1:0] epc;

  logic            int_req;
  logic            exc_req;
  logic            req;
  logic            wr_sr;
  logic            wr_epc;
  logic [IW-1:0]   hw_int_eff;

  assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = CP0_i_ExcValid & ~sr_exl;
  assign req     = (int_req | exc_req) & CP0_i_Reset_n;

  // A taken request flushes the M-stage instruction, so its mtc0 is dropped.
  assign wr_sr  = CP0_i_WE & ~req & (CP0_i_Addr == REG_SR);
  assign wr_epc = CP0_i_WE & ~req & (CP0_i_Addr == REG_EPC);

`ifdef CP0_COUNT_EN
  logic [XLEN-1:0] count;
  logic [XLEN-1:0] compare;
  logic            timer_pend;
  logic            wr_count;
  logic            wr_compare;

  assign wr_count   = CP0_i_WE & ~req & (CP0_i_Addr == REG_COUNT);
  assign wr_compare = CP0_i_WE & ~req & (CP0_i_Addr == REG_COMPARE);

  // Free-running counter and sticky compare-match pending bit.
  always_ff @(posedge CP0_i_Clk or negedge CP0_i_Reset_n) begin
    if (!CP0_i_Reset_n) begin
      count      <= '0;
      compare    <= '0;
      timer_pend <= 1'b0;
    end else begin
      if (wr_count) count <= CP0_i_WData;
      else          count <= count + XLEN'(1);
      if (wr_compare) begin
        compare    <= CP0_i_WData;
        timer_pend <= 1'b0;
      end else if ((count == compare) && (compare != '0)) begin
        timer_pend <= 1'b1;
      end
    end
  end

  assign hw_int_eff = {CP0_i_HWInt[5] | timer_pend, CP0_i_HWInt[4:0]};
`else
  assign hw_int_eff = CP0_i_HWInt;
`endif

  // SR/Cause/EPC update: request beats eret, eret beats an mtc0 to EXL.
  always_ff @(posedge CP0_i_Clk or negedge CP0_i_Reset_n) begin
    if (!CP0_i_Reset_n) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hw_int_eff;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? CW'(0) : CP0_i_ExcCode;
        cause_bd  <= CP0_i_BD;
        epc       <= CP0_i_BD ? (CP0_i_PC - XLEN'(4)) : CP0_i_PC;
      end else begin
        if (wr_sr) begin
          sr_im  <= CP0_i_WData[15:10];
          sr_exl <= CP0_i_WData[1];
          sr_ie  <= CP0_i_WData[0];
        end
        if (CP0_i_EXLClr) sr_exl <= 1'b0;
        if (wr_epc)       epc    <= CP0_i_WData;
      end
    end
  end

  // Combinational mfc0 read mux.
  always_comb begin
    CP0_o_RData = '0;
    case (CP0_i_Addr)
      REG_SR:    CP0_o_RData = {16'h0, sr_im, 8'h0, sr_exl, sr_ie};
      REG_CAUSE: CP0_o_RData = {cause_bd, 15'h0, cause_ip, 3'h0, cause_exc, 2'h0};
      REG_EPC:   CP0_o_RData = epc;
      REG_PRID:  CP0_o_RData = PRID;
`ifdef CP0_COUNT_EN
      REG_COUNT:   CP0_o_RData = count;
      REG_COMPARE: CP0_o_RData = compare;
`endif
      default:   CP0_o_RData = '0;
    endcase
  end

  assign CP0_o_EPC = epc;
  assign CP0_o_Req = req;

endmodule
